// File: rtl/ahfp_mul_multi.sv
// ahfp_mul_multi: 4-stage pipelined binary32 multiplier, round-to-nearest-even, denormals flushed to zero
module ahfp_mul_multi (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] dataa,
   input  logic [31:0] datab,
   output logic [31:0] result
);
   logic               a_zero, b_zero, a_max, b_max, a_nan, b_nan, a_inf, b_inf;
   logic               s1_sign, s1_zero, s1_inf, s1_nan;
   logic [9:0]         s1_ea, s1_eb;
   logic [23:0]        s1_ma, s1_mb;
   logic               s2_sign, s2_zero, s2_inf, s2_nan;
   logic signed [9:0]  s2_e;
   logic [47:0]        s2_p;
   logic               s3_sign, s3_zero, s3_inf, s3_nan;
   logic signed [9:0]  s3_e;
   logic [22:0]        s3_frac;
   logic               hi, g, st;
   logic [23:0]        m;
   logic [24:0]        mr;
   logic signed [9:0]  e3;
   logic [22:0]        frac3;
   logic [31:0]        res_d;

   always_comb begin
      a_zero = dataa[30:23] == 8'd0;
      b_zero = datab[30:23] == 8'd0;
      a_max  = &dataa[30:23];
      b_max  = &datab[30:23];
      a_nan  = a_max & |dataa[22:0];
      b_nan  = b_max & |datab[22:0];
      a_inf  = a_max & ~|dataa[22:0];
      b_inf  = b_max & ~|datab[22:0];
   end

   // leading one sits at bit 47 or 46; g is the first discarded bit, st the OR of the rest
   always_comb begin
      hi    = s2_p[47];
      m     = hi ? s2_p[47:24] : s2_p[46:23];
      g     = hi ? s2_p[23] : s2_p[22];
      st    = hi ? |s2_p[22:0] : |s2_p[21:0];
      mr    = {1'b0, m} + {24'd0, g & (st | m[0])};
      e3    = s2_e + $signed({9'd0, hi}) + $signed({9'd0, mr[24]});
      frac3 = mr[24] ? mr[23:1] : mr[22:0];
   end

   always_comb begin
      res_d = {s3_sign, s3_e[7:0], s3_frac};
      res_d = s3_e <= 10'sd0   ? {s3_sign, 31'd0} : res_d;
      res_d = s3_e >= 10'sd255 ? {s3_sign, 8'hFF, 23'd0} : res_d;
      res_d = s3_zero          ? {s3_sign, 31'd0} : res_d;
      res_d = s3_inf           ? {s3_sign, 8'hFF, 23'd0} : res_d;
      res_d = s3_nan           ? 32'h7FC00000 : res_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_sign <= 1'b0;
         s1_zero <= 1'b0;
         s1_inf  <= 1'b0;
         s1_nan  <= 1'b0;
         s1_ea   <= '0;
         s1_eb   <= '0;
         s1_ma   <= '0;
         s1_mb   <= '0;
         s2_sign <= 1'b0;
         s2_zero <= 1'b0;
         s2_inf  <= 1'b0;
         s2_nan  <= 1'b0;
         s2_e    <= '0;
         s2_p    <= '0;
         s3_sign <= 1'b0;
         s3_zero <= 1'b0;
         s3_inf  <= 1'b0;
         s3_nan  <= 1'b0;
         s3_e    <= '0;
         s3_frac <= '0;
         result  <= '0;
      end else begin
         s1_sign <= dataa[31] ^ datab[31];
         s1_zero <= a_zero | b_zero;
         s1_inf  <= a_inf | b_inf;
         s1_nan  <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
         s1_ea   <= {2'b00, dataa[30:23]};
         s1_eb   <= {2'b00, datab[30:23]};
         s1_ma   <= {~a_zero, dataa[22:0]};
         s1_mb   <= {~b_zero, datab[22:0]};
         s2_sign <= s1_sign;
         s2_zero <= s1_zero;
         s2_inf  <= s1_inf;
         s2_nan  <= s1_nan;
         s2_e    <= $signed(s1_ea + s1_eb - 10'd127);
         s2_p    <= s1_ma * s1_mb;
         s3_sign <= s2_sign;
         s3_zero <= s2_zero;
         s3_inf  <= s2_inf;
         s3_nan  <= s2_nan;
         s3_e    <= e3;
         s3_frac <= frac3;
         result  <= res_d;
      end
   end
endmodule

// File: tb/tb_ahfp_mul_multi.sv
// tb_ahfp_mul_multi: directed and random checks of the pipelined binary32 multiplier
module tb_ahfp_mul_multi;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] dataa = 32'h12345678;
   logic [31:0] datab = 32'h9ABCDEF0;
   logic [31:0] result;
   int          ncmp = 0;
   int          nerr = 0;
   logic [31:0] pe [4] = '{32'd0, 32'd0, 32'd0, 32'd0};
   string       pt [4] = '{"reset", "reset", "reset", "reset"};

   ahfp_mul_multi dut (
      .clk    (clk),
      .reset  (reset),
      .dataa  (dataa),
      .datab  (datab),
      .result (result)
   );

   always #5 clk = ~clk;

   // reference: the double product of two binary32 values is exact, then round to binary32 RNE
   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      real         ra, rb;
      logic [63:0] d;
      logic [10:0] e;
      ra = $bitstoreal({a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'd0});
      rb = $bitstoreal({b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0});
      d  = $realtobits(ra * rb);
      e  = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:29]} + {31'd0, d[28] & ((|d[27:0]) | d[29])};
   endfunction

   function automatic logic [31:0] rnd_op();
      return {1'($urandom), 8'($urandom_range(158, 96)), 23'($urandom)};
   endfunction

   // one clock: check the value applied four steps ago, then drive the next operands
   task automatic cyc(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e,
                      input logic r, input string t);
      @(posedge clk);
      #1;
      ncmp++;
      assert (result === pe[3])
      else begin
         nerr++;
         $error("FAIL %s: result=%h expected=%h", pt[3], result, pe[3]);
      end
      for (int i = 3; i > 0; i--) begin
         pe[i] = pe[i-1];
         pt[i] = pt[i-1];
      end
      if (r) for (int i = 1; i < 4; i++) begin
         pe[i] = 32'd0;
         pt[i] = "reset_flush";
      end
      pe[0] = r ? 32'd0 : e;
      pt[0] = r ? "in_reset" : t;
      reset = r;
      dataa = a;
      datab = b;
   endtask

   initial begin
      logic [31:0] ra, rb;
      cyc(32'hDEADBEEF, 32'h3F800000, 32'd0, 1'b1, "rst_a");
      cyc(32'h40000000, 32'h40400000, 32'd0, 1'b1, "rst_b");
      cyc(32'h00000000, 32'h00000000, 32'h00000000, 1'b0, "zero_x_zero");
      cyc(32'h3F800000, 32'h40000000, 32'h40000000, 1'b0, "one_x_two");
      cyc(32'h40000000, 32'h40800000, 32'h41000000, 1'b0, "two_x_four");
      cyc(32'h40400000, 32'h40600000, 32'h41280000, 1'b0, "three_x_3p5");
      cyc(32'h43FA0000, 32'h41133333, 32'h458FC000, 1'b0, "rnd1");
      cyc(32'h41EC0000, 32'h453BF800, 32'h47AD48A0, 1'b0, "rnd2");
      cyc(32'h42FF999A, 32'h42FCCCCD, 32'h467C67AF, 1'b0, "rnd3");
      cyc(32'h46A5E51F, 32'h435FAB85, 32'h4A90F1BC, 1'b0, "rnd4");
      cyc(32'h4640E400, 32'h47F12040, 32'h4EB5AEF1, 1'b0, "rnd5");
      cyc(32'h3F8E363B, 32'h3AA137F4, 32'h3AB31E61, 1'b0, "rnd6");
      cyc(32'hBF800000, 32'h40000000, 32'hC0000000, 1'b0, "sign_neg_pos");
      cyc(32'hBF800000, 32'hC0000000, 32'h40000000, 1'b0, "sign_neg_neg");
      cyc(32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, "sign_negzero");
      cyc(32'h7F800000, 32'h40000000, 32'h7F800000, 1'b0, "inf_x_two");
      cyc(32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0, "inf_x_zero");
      cyc(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b0, "nan_x_one");
      cyc(32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 1'b0, "overflow");
      cyc(32'h00800000, 32'h00800000, 32'h00000000, 1'b0, "underflow");
      cyc(32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, "denorm_flush");
      cyc(32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, "neginf_x_two");
      cyc(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 1'b0, "round_carry");
      cyc(32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0, "round_down");
      cyc(32'h40000000, 32'h40000000, 32'h40800000, 1'b0, "pre_rst_a");
      cyc(32'h40400000, 32'h40400000, 32'h41100000, 1'b0, "pre_rst_b");
      cyc(32'h40800000, 32'h40800000, 32'h41800000, 1'b0, "pre_rst_c");
      cyc(32'h3F800000, 32'h3F800000, 32'd0, 1'b1, "mid_rst");
      cyc(32'h40A00000, 32'h40000000, 32'h41200000, 1'b0, "post_rst");
      for (int i = 0; i < 1000; i++) begin
         ra = rnd_op();
         rb = rnd_op();
         cyc(ra, rb, ref_mul(ra, rb), 1'b0, $sformatf("rand%0d_%h_x_%h", i, ra, rb));
      end
      for (int i = 0; i < 4; i++) cyc(32'd0, 32'd0, 32'd0, 1'b0, "drain");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule

// File: doc/ahfp_mul_multi.md
Name: ahfp_mul_multi

Overview:
- Fully pipelined IEEE-754 single-precision floating-point multiplier with fixed latency.
- Accepts one operand pair per clock and produces result = dataa × datab a fixed number of cycles later.
- Used as the multi-cycle (pipelined) multiply datapath element in the arithmetic unit. No handshake; downstream logic tracks the fixed latency.

Parameters:
- None. Format is fixed at 32-bit binary32: 1 sign, 8 exponent (bias 127), 23 fraction.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- dataa  input  32  operand A, binary32
- datab  input  32  operand B, binary32
- result  output  32  product, binary32, registered

Behaviour:
- Interface: one clock (clk). reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset:
  - Every pipeline register and result clear to 32'h00000000.
  - Reset mid-operation discards all in-flight products.
  - result stays 0 until the first operands sampled after reset have traversed the pipe.
- Latency and throughput:
  - 4 register stages. Operands sampled at rising edge k appear on result immediately after edge k+3.
  - New operands are accepted every cycle; results emerge every cycle in order.
- Stage 1, input register / unpack:
  - sign = a[31] ^ b[31].
  - Exponents are zero-extended to 10 bits, signed working width.
  - Hidden bit is 1 when exponent != 0. Exponent 0 (zero or denormal) is flushed to zero.
  - Special-case flags are computed here: zero, inf, nan.
- Stage 2, multiply:
  - 24×24 unsigned mantissa product, 48 bits.
  - Exponent sum = ea + eb − 127.
- Stage 3, normalise and round:
  - If product[47] = 1, shift right by 1 and increment the exponent.
  - Round to nearest, ties to even, using guard, round and sticky bits from the discarded low product bits.
  - If rounding overflows the mantissa (carry to 2.0), renormalise and increment the exponent again.
- Stage 4, pack/special-case select, registered into result:
  - Either operand NaN, or inf × zero → 32'h7FC00000 (quiet NaN, sign 0).
  - inf × nonzero → sign, exponent 8'hFF, fraction 0.
  - Either operand zero or denormal (and no NaN/inf) → signed zero: {sign, 31'b0}.
  - Final biased exponent ≥ 255 → signed infinity.
  - Final biased exponent ≤ 0 → signed zero (no denormal outputs).
  - Otherwise → {sign, exp[7:0], frac[22:0]}.
- Boundaries:
  - Exact products (e.g. powers of two) carry no rounding error.
  - Sign is correct for all four sign combinations.
  - Back-to-back distinct operands every cycle must not interfere with each other.
- Maximum mantissa error versus the IEEE reference on normal results is 0 ulp.

Test Plan:
- Reset: assert reset 2 cycles with arbitrary inputs → result = 00000000 during reset and for 3 cycles after release. Assert reset while the pipe is full → all in-flight results lost; result = 00000000 on the next edge.
- Basic exact products, streamed one per cycle:
  - 00000000×00000000 → 00000000
  - 3F800000×40000000 → 40000000
  - 40000000×40800000 → 41000000
  - 40400000×40600000 → 41280000
  - Each appears exactly 4 cycles (edge k+3) after it is applied.
- Rounded products, streamed back-to-back:
  - 43FA0000×41133333 → 458FC000
  - 41EC0000×453BF800 → 47AD48A0
  - 42FF999A×42FCCCCD → 467C67AF
  - 46A5E51F×435FAB85 → 4A90F1BC
  - 4640E400×47F12040 → 4EB5AEF1
  - 3F8E363B×3AA137F4 → 3AB31E61
  - Required: 0 sign/exponent/mantissa difference.
- Signs: BF800000×40000000 → C0000000; BF800000×C0000000 → 40000000; 80000000×3F800000 → 80000000.
- Specials:
  - 7F800000×40000000 → 7F800000
  - 7F800000×00000000 → 7FC00000
  - 7FC00000×3F800000 → 7FC00000
  - 7F7FFFFF×40000000 → 7F800000 (overflow)
  - 00800000×00800000 → 00000000 (underflow)
  - 00000001×3F800000 → 00000000 (denormal flush)
- Throughput: random normal operands applied every cycle for 1000 cycles → each result matches an IEEE RNE reference model, delayed by exactly 4 cycles.
